// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock, with ready/start/done handshake.
// Optional leading-zero blank mask enabled by defining BCD_CONV_LEADING_BLANK_EN.
module bcd_seq_converter #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   shifted;
    logic               ovf_scr;
    logic               ovf_next;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last;

    assign ready = (state == IDLE);

    // Adjust every digit >= 5 before the shift so no digit exceeds 9 afterwards.
    always_comb begin
        adjusted = scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        shifted  = {adjusted[BCD_W-2:0], shreg[BIN_W-1]};
        ovf_next = ovf_scr | adjusted[BCD_W-1];
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            scratch  <= '0;
            ovf_scr  <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                shreg   <= bin;
                scratch <= '0;
                ovf_scr <= 1'b0;
                cnt     <= CNT_W'(BIN_W);
            end else if (state == SHIFT) begin
                shreg   <= shreg << 1;
                scratch <= shifted;
                ovf_scr <= ovf_next;
                cnt     <= cnt - 1'b1;
            end
            if (last) begin
                bcd      <= shifted;
                overflow <= ovf_next;
            end
        end
    end

`ifdef BCD_CONV_LEADING_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [DIGITS-1:0] blank_next;
    logic              zero_above;

    // Scan from the top digit down; blanking stops at the first nonzero digit.
    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        if (!ovf_next) begin
            for (int unsigned i = 0; i < DIGITS - 1; i++) begin
                if (zero_above && (shifted[4*(DIGITS-1-i) +: 4] == 4'd0)) begin
                    blank_next[DIGITS-1-i] = 1'b1;
                end else begin
                    zero_above = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= BLANK_RST;
        end else if (last) begin
            blank <= blank_next;
        end
    end
`else
    assign blank = '0;
`endif

endmodule
